// File: rtl/fmul16_pkg.sv
// Shared types and widths for the fmul16 datapath slices.
package fmul16_pkg;

   localparam int unsigned F16_FRAC_W = 10;
   localparam int unsigned SIG_MUL_W  = 22;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } rm_e;

endpackage

// File: rtl/fmul16_rsh_lgs_mask.sv
// Right-shift L/G/S mask generator: maps a subnormal shift amount onto
// one-hot L and G masks over the significand product plus a sticky mask
// covering every bit below G. A G position past the top of the product
// means the whole product lies below G, so the sticky mask is all ones.
module fmul16_rsh_lgs_mask
   import fmul16_pkg::*;
#(
   parameter int unsigned RSH_W = 5
) (
   input  logic [RSH_W-1:0]     rsh_num_i,
   output logic [SIG_MUL_W-1:0] l_mask_o,
   output logic [SIG_MUL_W-1:0] g_mask_o,
   output logic [SIG_MUL_W-1:0] s_mask_o
);

   logic [31:0] g_pos;

   assign g_pos = 32'(rsh_num_i) + 32'(F16_FRAC_W) - 32'd1;

   // One-hot L and G masks; positions beyond the product leave the mask empty
   always_comb begin
      l_mask_o = '0;
      g_mask_o = '0;
      for (int unsigned i = 0; i < SIG_MUL_W; i++) begin
         l_mask_o[i] = (g_pos + 32'd1 == i);
         g_mask_o[i] = (g_pos == i);
      end
   end

   // Sticky mask as prefix-OR of the G mask, scanned from the MSB downwards
   always_comb begin
      logic acc;
      acc      = (g_pos >= 32'(SIG_MUL_W));
      s_mask_o = '0;
      for (int unsigned k = 0; k < SIG_MUL_W; k++) begin
         s_mask_o[SIG_MUL_W-1-k] = acc;
         acc                     = acc | g_mask_o[SIG_MUL_W-1-k];
      end
   end

endmodule

// File: rtl/fmul16_rsh_round_pipe.sv
// fmul16 underflow path: right-shifts a tiny significand product into the
// F16 subnormal field, extracts L/G/S, rounds per rm and emits the packed
// result with NX/UF. Two-stage valid/ready pipeline, one beat per cycle.
module fmul16_rsh_round_pipe
   import fmul16_pkg::*;
#(
   parameter int unsigned RSH_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 sign_i,
   input  logic [SIG_MUL_W-1:0] sig_mul_i,
   input  logic [RSH_W-1:0]     rsh_num_i,
   input  logic [2:0]           rm_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [15:0]          res_o,
   output logic                 fflags_nx_o,
   output logic                 fflags_uf_o
);

   localparam int unsigned Q_W = F16_FRAC_W + 1;

   // handshake
   logic s1_v_q, s1_v_d;
   logic s2_v_q, s2_v_d;
   logic s2_load;
   logic in_fire;
   logic s2_fill;

   // stage 1 data
   logic [Q_W-1:0] s1_q_q, s1_q_d;
   logic           s1_l_q, s1_l_d;
   logic           s1_g_q, s1_g_d;
   logic           s1_s_q, s1_s_d;
   logic           s1_sign_q, s1_sign_d;
   logic [2:0]     s1_rm_q, s1_rm_d;

   // stage 2 data
   logic [15:0]    res_q, res_d;
   logic           nx_q, nx_d;
   logic           uf_q, uf_d;

   // combinational helpers
   logic [SIG_MUL_W-1:0] l_mask, g_mask, s_mask;
   logic [Q_W-1:0]       sh_q;
   logic                 rnd_up;
   logic [Q_W-1:0]       q_r;

   fmul16_rsh_lgs_mask #(
      .RSH_W (RSH_W)
   ) u_lgs_mask (
      .rsh_num_i (rsh_num_i),
      .l_mask_o  (l_mask),
      .g_mask_o  (g_mask),
      .s_mask_o  (s_mask)
   );

   // S2 frees up when empty or drained; S1 may take input whenever it is empty
   // or about to advance, which equals ~s1_v | ~s2_v | out_ready_i.
   assign s2_load    = ~s2_v_q | out_ready_i;
   assign in_ready_o = ~s1_v_q | s2_load;
   assign in_fire    = in_valid_i & in_ready_o;
   assign s2_fill    = s2_load & s1_v_q;

   assign sh_q = Q_W'(sig_mul_i >> (32'(rsh_num_i) + 32'(F16_FRAC_W)));

   // Stage 1 next state: capture shifted quotient and L/G/S on input transfer
   always_comb begin
      s1_v_d    = in_ready_o ? in_valid_i : s1_v_q;
      s1_q_d    = s1_q_q;
      s1_l_d    = s1_l_q;
      s1_g_d    = s1_g_q;
      s1_s_d    = s1_s_q;
      s1_sign_d = s1_sign_q;
      s1_rm_d   = s1_rm_q;
      if (in_fire) begin
         s1_q_d    = sh_q;
         s1_l_d    = |(sig_mul_i & l_mask);
         s1_g_d    = |(sig_mul_i & g_mask);
         s1_s_d    = |(sig_mul_i & s_mask);
         s1_sign_d = sign_i;
         s1_rm_d   = rm_i;
      end
   end

   // Round-up decision by rounding mode; unused encodings round to nearest even
   always_comb begin
      rnd_up = 1'b0;
      case (s1_rm_q)
         RTZ:     rnd_up = 1'b0;
         RDN:     rnd_up = s1_sign_q & (s1_g_q | s1_s_q);
         RUP:     rnd_up = ~s1_sign_q & (s1_g_q | s1_s_q);
         RMM:     rnd_up = s1_g_q;
         default: rnd_up = s1_g_q & (s1_l_q | s1_s_q);
      endcase
   end

   assign q_r = s1_q_q + Q_W'(rnd_up);

   // Stage 2 next state: a carry into bit 10 lands on exp=1, frac=0 for free
   always_comb begin
      s2_v_d = s2_load ? s1_v_q : s2_v_q;
      res_d  = res_q;
      nx_d   = nx_q;
      uf_d   = uf_q;
      if (s2_fill) begin
         res_d = {s1_sign_q, 4'b0000, q_r};
         nx_d  = s1_g_q | s1_s_q;
         uf_d  = s1_g_q | s1_s_q;
      end
   end

   // Pipeline registers with synchronous reset dropping all in-flight beats
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         s1_q_q    <= '0;
         s1_l_q    <= 1'b0;
         s1_g_q    <= 1'b0;
         s1_s_q    <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_rm_q   <= '0;
         res_q     <= '0;
         nx_q      <= 1'b0;
         uf_q      <= 1'b0;
      end else begin
         s1_v_q    <= s1_v_d;
         s2_v_q    <= s2_v_d;
         s1_q_q    <= s1_q_d;
         s1_l_q    <= s1_l_d;
         s1_g_q    <= s1_g_d;
         s1_s_q    <= s1_s_d;
         s1_sign_q <= s1_sign_d;
         s1_rm_q   <= s1_rm_d;
         res_q     <= res_d;
         nx_q      <= nx_d;
         uf_q      <= uf_d;
      end
   end

   assign out_valid_o = s2_v_q;
   assign res_o       = res_q;
   assign fflags_nx_o = nx_q;
   assign fflags_uf_o = uf_q;

   // Accepted beats must be a legal tiny product with a nonzero shift
   a_legal_input : assert property (@(posedge clk) disable iff (rst)
      in_fire |-> ((rsh_num_i != '0) &&
                   ((sig_mul_i >> (32'(rsh_num_i) + 32'(F16_FRAC_W))) < 22'h400)));

endmodule

// File: tb/tb_fmul16_rsh_round_pipe.sv
// Bench for fmul16_rsh_round_pipe: directed vector table, backpressure and
// reset sequences, then randomized traffic against an arithmetic model.
module tb_fmul16_rsh_round_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic        sign_i;
   logic [21:0] sig_mul_i;
   logic [4:0]  rsh_num_i;
   logic [2:0]  rm_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [15:0] res_o;
   logic        fflags_nx_o;
   logic        fflags_uf_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        sign;
      logic [21:0] sig;
      logic [4:0]  rsh;
      logic [2:0]  rm;
      logic [15:0] res;
      logic        nx;
      logic        uf;
   } vec_t;

   typedef struct packed {
      logic [15:0] res;
      logic        nx;
      logic        uf;
   } exp_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];
   exp_t exp_q [$];

   fmul16_rsh_round_pipe #(
      .RSH_W (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .sign_i      (sign_i),
      .sig_mul_i   (sig_mul_i),
      .rsh_num_i   (rsh_num_i),
      .rm_i        (rm_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .res_o       (res_o),
      .fflags_nx_o (fflags_nx_o),
      .fflags_uf_o (fflags_uf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Value is sig / 2^(34+rsh); in units of the smallest subnormal (2^-24)
   // that is sig / 2^(10+rsh). Round the quotient by remainder vs half-unit.
   function automatic exp_t model(input logic sgn, input logic [21:0] sig,
                                  input logic [4:0] rsh, input logic [2:0] rm);
      longint unsigned unit, quo, rem, half;
      logic up;
      exp_t e;
      unit = 64'd1 << (10 + int'(rsh));
      quo  = 64'(sig) / unit;
      rem  = 64'(sig) % unit;
      half = unit / 2;
      case (rm)
         3'd1:    up = 1'b0;
         3'd2:    up = sgn && (rem != 0);
         3'd3:    up = !sgn && (rem != 0);
         3'd4:    up = (rem >= half);
         default: up = (rem > half) || ((rem == half) && (quo % 2 == 1));
      endcase
      e.res = {sgn, 15'(quo + 64'(up))};
      e.nx  = (rem != 0);
      e.uf  = (rem != 0);
      return e;
   endfunction

   task automatic drive_vec(input vec_t v);
      sign_i    = v.sign;
      sig_mul_i = v.sig;
      rsh_num_i = v.rsh;
      rm_i      = v.rm;
   endtask

   task automatic rand_beat();
      sign_i    = 1'($urandom_range(0, 1));
      rsh_num_i = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(1, 4)) : 5'($urandom_range(1, 31));
      sig_mul_i = 22'($urandom);
      if (rsh_num_i == 5'd1) sig_mul_i[21] = 1'b0;
      rm_i      = 3'($urandom_range(0, 7));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [15:0] hold_res;
      logic hold_v;
      int idx;

      vecs[0]  = '{1'b0, 22'h100000, 5'd1,  3'd0, 16'h0200, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 22'h1FFFFF, 5'd1,  3'd0, 16'h0400, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 22'h1FFFFF, 5'd1,  3'd1, 16'h03FF, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 22'h100C00, 5'd1,  3'd0, 16'h0202, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 22'h100C00, 5'd1,  3'd1, 16'h0201, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 22'h100C00, 5'd1,  3'd2, 16'h8202, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 22'h100C00, 5'd1,  3'd4, 16'h0202, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 22'h100000, 5'd20, 3'd3, 16'h0001, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 22'h100000, 5'd20, 3'd1, 16'h0000, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 22'h100000, 5'd20, 3'd2, 16'h8001, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 22'h000000, 5'd5,  3'd0, 16'h8000, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 22'h100C00, 5'd1,  3'd7, 16'h0202, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 22'h100400, 5'd1,  3'd0, 16'h0200, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 22'h100400, 5'd1,  3'd4, 16'h0201, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 22'h200000, 5'd12, 3'd0, 16'h0000, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 22'h200000, 5'd12, 3'd4, 16'h0001, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 22'h200000, 5'd13, 3'd3, 16'h0001, 1'b1, 1'b1};
      vecs[17] = '{1'b1, 22'h000001, 5'd31, 3'd2, 16'h8001, 1'b1, 1'b1};
      vecs[18] = '{1'b1, 22'h1FFFFF, 5'd1,  3'd3, 16'h83FF, 1'b1, 1'b1};
      vecs[19] = '{1'b0, 22'h1FFFFF, 5'd1,  3'd2, 16'h03FF, 1'b1, 1'b1};

      rst         = 1'b1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      drive_vec(vecs[0]);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_res",       32'(res_o),       32'd0);
      check("rst_nx",        32'(fflags_nx_o), 32'd0);
      check("rst_uf",        32'(fflags_uf_o), 32'd0);
      check("rst_in_ready",  32'(in_ready_o),  32'd1);

      // Directed table: single beats, 2-cycle latency
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive_vec(vecs[i]);
         in_valid_i  = 1'b1;
         out_ready_i = 1'b1;
         #1;
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready_o), 32'd1);
         @(negedge clk);
         in_valid_i = 1'b0;
         check($sformatf("vec%0d_lat1", i), 32'(out_valid_o), 32'd0);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'd1);
         check($sformatf("vec%0d_res", i),   32'(res_o),       32'(vecs[i].res));
         check($sformatf("vec%0d_nx", i),    32'(fflags_nx_o), 32'(vecs[i].nx));
         check($sformatf("vec%0d_uf", i),    32'(fflags_uf_o), 32'(vecs[i].uf));
      end
      @(negedge clk);
      check("after_table_idle", 32'(out_valid_o), 32'd0);

      // Backpressure: 3 back-to-back beats while downstream stalls
      out_ready_i = 1'b0;
      drive_vec(vecs[0]);
      in_valid_i = 1'b1;
      #1;
      check("bp_ready0", 32'(in_ready_o), 32'd1);
      @(negedge clk);
      drive_vec(vecs[2]);
      #1;
      check("bp_ready1", 32'(in_ready_o), 32'd1);
      @(negedge clk);
      drive_vec(vecs[5]);
      #1;
      check("bp_ready_drop", 32'(in_ready_o), 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("bp_stall_ready", 32'(in_ready_o),  32'd0);
         check("bp_stall_valid", 32'(out_valid_o), 32'd1);
         check("bp_stall_res",   32'(res_o),       32'(vecs[0].res));
      end
      out_ready_i = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready_o), 32'd1);
      check("bp_out0", 32'(res_o), 32'(vecs[0].res));
      idx = 1;
      for (int c = 0; c < 8 && idx < 3; c++) begin
         @(negedge clk);
         in_valid_i = 1'b0;
         #1;
         if (out_valid_o) begin
            check($sformatf("bp_out%0d", idx), 32'(res_o), 32'((idx == 1) ? vecs[2].res : vecs[5].res));
            idx++;
         end
      end
      check("bp_count", 32'(idx), 32'd3);
      @(negedge clk);
      check("bp_no_extra", 32'(out_valid_o), 32'd0);

      // Reset with two beats in flight
      out_ready_i = 1'b0;
      drive_vec(vecs[3]);
      in_valid_i = 1'b1;
      @(negedge clk);
      drive_vec(vecs[4]);
      @(negedge clk);
      in_valid_i = 1'b0;
      check("rr_inflight_valid", 32'(out_valid_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rr_valid", 32'(out_valid_o), 32'd0);
      check("rr_res",   32'(res_o),       32'd0);
      check("rr_ready", 32'(in_ready_o),  32'd1);
      out_ready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rr_no_stale", 32'(out_valid_o), 32'd0);
      end
      drive_vec(vecs[7]);
      in_valid_i = 1'b1;
      @(negedge clk);
      in_valid_i = 1'b0;
      check("rr_lat1", 32'(out_valid_o), 32'd0);
      @(negedge clk);
      check("rr_lat2_valid", 32'(out_valid_o), 32'd1);
      check("rr_lat2_res",   32'(res_o),       32'(vecs[7].res));

      // Randomized traffic against the model with a scoreboard queue
      @(negedge clk);
      exp_q.delete();
      hold_v   = 1'b0;
      hold_res = '0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (hold_v) begin
            check("rnd_hold_valid", 32'(out_valid_o), 32'd1);
            check("rnd_hold_res",   32'(res_o),       32'(hold_res));
         end
         in_valid_i  = ($urandom_range(0, 3) != 0);
         out_ready_i = ($urandom_range(0, 2) != 0);
         rand_beat();
         #1;
         check("rnd_in_ready", 32'(in_ready_o), 32'((exp_q.size() < 2) || out_ready_i));
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               check("rnd_unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rnd_res", 32'(res_o),       32'(e.res));
               check("rnd_nx",  32'(fflags_nx_o), 32'(e.nx));
               check("rnd_uf",  32'(fflags_uf_o), 32'(e.uf));
            end
         end
         if (in_valid_i && in_ready_o)
            exp_q.push_back(model(sign_i, sig_mul_i, rsh_num_i, rm_i));
         hold_v   = out_valid_o && !out_ready_i;
         hold_res = res_o;
      end

      // Drain remaining beats
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (out_valid_o) begin
            if (exp_q.size() == 0) begin
               check("drain_unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("drain_res", 32'(res_o), 32'(e.res));
            end
         end
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
